// File: rtl/ecies_encrypt_if.sv
// Host-side bundle of ecies_encrypt: request, curve/key inputs and packed result.
interface ecies_encrypt_if #(
  parameter int message_width = 32,
  parameter int integer_size  = 64,
  parameter int key_size      = 128,
  parameter int hashed_width  = 512
);
  localparam int FCW = 2*integer_size + message_width + hashed_width;

  logic                     go;
  logic [key_size-1:0]      k_eph;
  logic [key_size-1:0]      n;
  logic [integer_size-1:0]  prime;
  logic [integer_size-1:0]  A;
  logic [integer_size-1:0]  B;
  logic [integer_size-1:0]  Gx;
  logic [integer_size-1:0]  Gy;
  logic [integer_size-1:0]  pubQx;
  logic [integer_size-1:0]  pubQy;
  logic [message_width-1:0] plaintext;
  logic [FCW-1:0]           full_cipher;
  logic                     done;
  logic                     valid;

  modport master (
    output go, k_eph, n, prime, A, B,
    output Gx, Gy, pubQx, pubQy, plaintext,
    input  full_cipher, done, valid
  );

  modport slave (
    input  go, k_eph, n, prime, A, B,
    input  Gx, Gy, pubQx, pubQy, plaintext,
    output full_cipher, done, valid
  );
endinterface

// File: rtl/ecies_encrypt.sv
// ecies_encrypt: sender-side ECIES sequencer (k*G, k*Q, KDF, encrypt, MAC).
// Define ECIES_PUBKEY_CHECK_EN to validate Q (Q != inf, n*Q == inf) first.
module ecies_encrypt #(
  parameter int message_width  = 32,
  parameter int integer_size   = 64,
  parameter int key_size       = 128,
  parameter int hashed_width   = 512,
  parameter int enc_key_len    = 128,
  parameter int mac_key_length = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  ecies_encrypt_if.slave         host,
  output logic                   ecc_go,
  output logic [key_size-1:0]    ecc_k,
  output logic [integer_size-1:0] ecc_Px,
  output logic [integer_size-1:0] ecc_Py,
  output logic [integer_size-1:0] ecc_prime,
  output logic [integer_size-1:0] ecc_A,
  output logic [integer_size-1:0] ecc_B,
  input  logic                   ecc_done,
  input  logic                   ecc_inf,
  input  logic [integer_size-1:0] ecc_Rx,
  input  logic [integer_size-1:0] ecc_Ry,
  output logic                   kdf_go,
  output logic [integer_size-1:0] kdf_z,
  input  logic                   kdf_done,
  input  logic [enc_key_len+mac_key_length-1:0] kdf_key,
  output logic                   enc_go,
  output logic [enc_key_len-1:0] enc_key,
  output logic [message_width-1:0] enc_data,
  input  logic                   enc_done,
  input  logic [message_width-1:0] enc_result,
  output logic                   hash_go,
  output logic [mac_key_length-1:0] mac_key,
  output logic [message_width-1:0] hash_data,
  input  logic                   hash_done,
  input  logic [hashed_width-1:0] hash_out
);
  localparam int FCW = 2*integer_size + message_width + hashed_width;
  localparam int KKW = enc_key_len + mac_key_length;

  typedef enum logic [3:0] {
    IDLE,
`ifdef ECIES_PUBKEY_CHECK_EN
    QINF,
    QORDER,
`endif
    GEN_R,
    GEN_S,
    KDF,
    ENCRYPT,
    MAC,
    DONEOUT
  } state_t;

  state_t                    state_q;
  logic [key_size-1:0]       k_q;
`ifdef ECIES_PUBKEY_CHECK_EN
  logic [key_size-1:0]       n_q;
`endif
  logic [integer_size-1:0]   prime_q, a_q, b_q;
  logic [integer_size-1:0]   gx_q, gy_q, qx_q, qy_q;
  logic [message_width-1:0]  pt_q;
  logic [integer_size-1:0]   rx_q, ry_q, sx_q;
  logic [message_width-1:0]  c_q;
  logic [hashed_width-1:0]   tag_q;
  logic [enc_key_len-1:0]    enc_key_q;
  logic [mac_key_length-1:0] mac_key_q;
  logic                      ok_q;
  logic                      ecc_go_q, kdf_go_q;
  logic                      enc_go_q, hash_go_q;
  logic [key_size-1:0]       ecc_k_q;
  logic [integer_size-1:0]   ecc_px_q, ecc_py_q;
  logic                      done_q, valid_q;
  logic [FCW-1:0]            fc_q;

  logic ecc_hit, k_bad;
  assign ecc_hit = ecc_go_q & ecc_done;
  assign k_bad   = (host.k_eph == '0) | (host.k_eph >= host.n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
`ifdef ECIES_PUBKEY_CHECK_EN
      n_q       <= '0;
`endif
      prime_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      pt_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      sx_q      <= '0;
      c_q       <= '0;
      tag_q     <= '0;
      enc_key_q <= '0;
      mac_key_q <= '0;
      ok_q      <= 1'b0;
      ecc_go_q  <= 1'b0;
      kdf_go_q  <= 1'b0;
      enc_go_q  <= 1'b0;
      hash_go_q <= 1'b0;
      ecc_k_q   <= '0;
      ecc_px_q  <= '0;
      ecc_py_q  <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      fc_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.go) begin
            k_q     <= host.k_eph;
`ifdef ECIES_PUBKEY_CHECK_EN
            n_q     <= host.n;
`endif
            prime_q <= host.prime;
            a_q     <= host.A;
            b_q     <= host.B;
            gx_q    <= host.Gx;
            gy_q    <= host.Gy;
            qx_q    <= host.pubQx;
            qy_q    <= host.pubQy;
            pt_q    <= host.plaintext;
            ok_q    <= 1'b0;
            if (k_bad) begin
              state_q <= DONEOUT;
            end else begin
              ecc_go_q <= 1'b1;
`ifdef ECIES_PUBKEY_CHECK_EN
              state_q  <= QINF;
              ecc_k_q  <= key_size'(1);
              ecc_px_q <= host.pubQx;
              ecc_py_q <= host.pubQy;
`else
              state_q  <= GEN_R;
              ecc_k_q  <= host.k_eph;
              ecc_px_q <= host.Gx;
              ecc_py_q <= host.Gy;
`endif
            end
          end
        end
`ifdef ECIES_PUBKEY_CHECK_EN
        QINF: begin
          if (ecc_hit) begin
            ecc_go_q <= 1'b0;
            state_q  <= ecc_inf ? DONEOUT : QORDER;
          end else if (!ecc_go_q && !ecc_done) begin
            ecc_go_q <= 1'b1;
            ecc_k_q  <= key_size'(1);
            ecc_px_q <= qx_q;
            ecc_py_q <= qy_q;
          end
        end
        QORDER: begin
          // A valid Q has order n, so n*Q must land on infinity.
          if (ecc_hit) begin
            ecc_go_q <= 1'b0;
            state_q  <= ecc_inf ? GEN_R : DONEOUT;
          end else if (!ecc_go_q && !ecc_done) begin
            ecc_go_q <= 1'b1;
            ecc_k_q  <= n_q;
            ecc_px_q <= qx_q;
            ecc_py_q <= qy_q;
          end
        end
`endif
        GEN_R: begin
          if (ecc_hit) begin
            ecc_go_q <= 1'b0;
            if (ecc_inf) begin
              state_q <= DONEOUT;
            end else begin
              rx_q    <= ecc_Rx;
              ry_q    <= ecc_Ry;
              state_q <= GEN_S;
            end
          end else if (!ecc_go_q && !ecc_done) begin
            ecc_go_q <= 1'b1;
            ecc_k_q  <= k_q;
            ecc_px_q <= gx_q;
            ecc_py_q <= gy_q;
          end
        end
        GEN_S: begin
          // Multiplier must drop done from the last job before re-arming.
          if (ecc_hit) begin
            ecc_go_q <= 1'b0;
            if (ecc_inf) begin
              state_q <= DONEOUT;
            end else begin
              sx_q    <= ecc_Rx;
              state_q <= KDF;
            end
          end else if (!ecc_go_q && !ecc_done) begin
            ecc_go_q <= 1'b1;
            ecc_k_q  <= k_q;
            ecc_px_q <= qx_q;
            ecc_py_q <= qy_q;
          end
        end
        KDF: begin
          if (kdf_go_q && kdf_done) begin
            kdf_go_q  <= 1'b0;
            enc_key_q <= kdf_key[KKW-1 -: enc_key_len];
            mac_key_q <= kdf_key[mac_key_length-1:0];
            state_q   <= ENCRYPT;
          end else if (!kdf_go_q) begin
            kdf_go_q <= 1'b1;
          end
        end
        ENCRYPT: begin
          if (enc_go_q && enc_done) begin
            enc_go_q <= 1'b0;
            c_q      <= enc_result;
            state_q  <= MAC;
          end else if (!enc_go_q) begin
            enc_go_q <= 1'b1;
          end
        end
        MAC: begin
          if (hash_go_q && hash_done) begin
            hash_go_q <= 1'b0;
            tag_q     <= hash_out;
            ok_q      <= 1'b1;
            state_q   <= DONEOUT;
          end else if (!hash_go_q) begin
            hash_go_q <= 1'b1;
          end
        end
        DONEOUT: begin
          if (!done_q) begin
            done_q  <= 1'b1;
            valid_q <= ok_q;
            fc_q    <= ok_q ? {rx_q, ry_q, c_q, tag_q} : '0;
          end else if (!host.go) begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            fc_q    <= '0;
            ok_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ecc_go    = ecc_go_q;
  assign ecc_k     = ecc_k_q;
  assign ecc_Px    = ecc_px_q;
  assign ecc_Py    = ecc_py_q;
  assign ecc_prime = prime_q;
  assign ecc_A     = a_q;
  assign ecc_B     = b_q;
  assign kdf_go    = kdf_go_q;
  assign kdf_z     = sx_q;
  assign enc_go    = enc_go_q;
  assign enc_key   = enc_key_q;
  assign enc_data  = pt_q;
  assign hash_go   = hash_go_q;
  assign mac_key   = mac_key_q;
  assign hash_data = c_q;

  assign host.full_cipher = fc_q;
  assign host.done        = done_q;
  assign host.valid       = valid_q;
endmodule

// File: tb/tb_ecies_encrypt.sv
// Scoreboard bench for ecies_encrypt with stub EC/KDF/cipher/MAC engines.
// Define ECIES_PUBKEY_CHECK_EN to also exercise the public-key checks.
module tb_ecies_encrypt;
  localparam int MW  = 32;
  localparam int IW  = 64;
  localparam int KS  = 128;
  localparam int HW  = 512;
  localparam int EKL = 128;
  localparam int MKL = 256;
  localparam int FW  = 2*IW + MW + HW;
`ifdef ECIES_PUBKEY_CHECK_EN
  localparam int NMUL = 4;
`else
  localparam int NMUL = 2;
`endif

  localparam logic [HW-1:0]  TAG  = {16{32'h5555_5555}};
  localparam logic [EKL-1:0] EKEY = {32{4'h1}};
  localparam logic [MKL-1:0] MKEY = {64{4'h2}};
  localparam logic [FW-1:0]  NOM  =
    {64'h0A, 64'h0B, 32'hDEAD_BEEF, TAG};

  typedef struct packed {
    logic          v;
    logic [FW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecies_encrypt_if #(
    .message_width(MW), .integer_size(IW),
    .key_size(KS), .hashed_width(HW)
  ) hif ();

  logic           ecc_go, ecc_done, ecc_inf;
  logic [KS-1:0]  ecc_k;
  logic [IW-1:0]  ecc_Px, ecc_Py, ecc_prime, ecc_A, ecc_B;
  logic [IW-1:0]  ecc_Rx, ecc_Ry;
  logic           kdf_go, kdf_done;
  logic [IW-1:0]  kdf_z;
  logic [EKL+MKL-1:0] kdf_key;
  logic           enc_go, enc_done;
  logic [EKL-1:0] enc_key;
  logic [MW-1:0]  enc_data, enc_result;
  logic           hash_go, hash_done;
  logic [MKL-1:0] mac_key;
  logic [MW-1:0]  hash_data;
  logic [HW-1:0]  hash_out;

  ecies_encrypt #(
    .message_width(MW), .integer_size(IW), .key_size(KS),
    .hashed_width(HW), .enc_key_len(EKL), .mac_key_length(MKL)
  ) dut (
    .clk(clk), .rst(rst), .host(hif),
    .ecc_go(ecc_go), .ecc_k(ecc_k),
    .ecc_Px(ecc_Px), .ecc_Py(ecc_Py),
    .ecc_prime(ecc_prime), .ecc_A(ecc_A), .ecc_B(ecc_B),
    .ecc_done(ecc_done), .ecc_inf(ecc_inf),
    .ecc_Rx(ecc_Rx), .ecc_Ry(ecc_Ry),
    .kdf_go(kdf_go), .kdf_z(kdf_z),
    .kdf_done(kdf_done), .kdf_key(kdf_key),
    .enc_go(enc_go), .enc_key(enc_key), .enc_data(enc_data),
    .enc_done(enc_done), .enc_result(enc_result),
    .hash_go(hash_go), .mac_key(mac_key), .hash_data(hash_data),
    .hash_done(hash_done), .hash_out(hash_out)
  );

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  logic [MW-1:0] exp_pt;
  bit inf2 = 0, stuck = 0, ord_inf = 1;
  int ecc_r = 0, kdf_r = 0, enc_r = 0, hash_r = 0;

  task automatic chk(string nm, logic [FW-1:0] act,
                     logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  assign kdf_key    = {EKEY, MKEY};
  assign enc_result = 32'hDEAD_BEEF;
  assign hash_out   = TAG;

  // Multiplier stub: result chosen by scalar and base point.
  int ecnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecc_done <= 1'b0; ecc_inf <= 1'b0;
      ecc_Rx <= '0; ecc_Ry <= '0; ecnt <= 0;
    end else if (ecc_done) begin
      if (!stuck) ecc_done <= 1'b0;
      ecnt <= 0;
    end else if (ecc_go) begin
      if (ecnt == 2) begin
        ecc_done <= 1'b1;
        if (ecc_k == KS'(1)) begin
          ecc_inf <= 1'b0; ecc_Rx <= ecc_Px; ecc_Ry <= ecc_Py;
        end else if (ecc_k == hif.n) begin
          ecc_inf <= ord_inf; ecc_Rx <= '0; ecc_Ry <= '0;
        end else if (ecc_Px == hif.Gx) begin
          ecc_inf <= 1'b0; ecc_Rx <= 64'h0A; ecc_Ry <= 64'h0B;
        end else begin
          ecc_inf <= inf2; ecc_Rx <= 64'h0C; ecc_Ry <= 64'h0D;
        end
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  int kc, ec, hc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      kdf_done <= 0; enc_done <= 0; hash_done <= 0;
      kc <= 0; ec <= 0; hc <= 0;
    end else begin
      if (kdf_done) begin kdf_done <= 0; kc <= 0; end
      else if (kdf_go) begin
        if (kc == 1) kdf_done <= 1; else kc <= kc + 1;
      end
      if (enc_done) begin enc_done <= 0; ec <= 0; end
      else if (enc_go) begin
        if (ec == 2) enc_done <= 1; else ec <= ec + 1;
      end
      if (hash_done) begin hash_done <= 0; hc <= 0; end
      else if (hash_go) begin
        if (hc == 3) hash_done <= 1; else hc <= hc + 1;
      end
    end
  end

  // Monitor: engine operands on go rise, results on done rise.
  logic pe = 0, pk = 0, pn = 0, ph = 0, pd = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ecc_go && !pe) ecc_r++;
    if (kdf_go && !pk) begin
      kdf_r++;
      chk("kdf_z", FW'(kdf_z), FW'(64'h0C));
    end
    if (enc_go && !pn) begin
      enc_r++;
      chk("enc_data", FW'(enc_data), FW'(exp_pt));
      chk("enc_key", FW'(enc_key), FW'(EKEY));
    end
    if (hash_go && !ph) begin
      hash_r++;
      chk("hash_data", FW'(hash_data), FW'(32'hDEAD_BEEF));
      chk("mac_key", FW'(mac_key), FW'(MKEY));
    end
    if (hif.done && !pd) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: got done=1 want none");
      end else begin
        e = sb.pop_front();
        chk("valid", FW'(hif.valid), FW'(e.v));
        chk("full_cipher", hif.full_cipher, e.fc);
      end
    end
    pe = ecc_go; pk = kdf_go; pn = enc_go;
    ph = hash_go; pd = hif.done;
  end

  task automatic clr();
    @(posedge clk); #1;
    ecc_r = 0; kdf_r = 0; enc_r = 0; hash_r = 0;
  endtask

  task automatic wait_done(string nm);
    int t = 0;
    while (!hif.done && t < 400) begin
      @(negedge clk); t++;
    end
    if (!hif.done) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: got done=0 want 1", nm);
    end
  endtask

  task automatic finish_run();
    @(negedge clk); hif.go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(string nm, logic [KS-1:0] k,
                     logic [MW-1:0] pt, bit ok);
    exp_t e;
    @(negedge clk);
    hif.k_eph = k; hif.plaintext = pt; exp_pt = pt;
    e.v = ok; e.fc = ok ? NOM : '0;
    sb.push_back(e);
    hif.go = 1'b1;
    wait_done(nm);
    finish_run();
  endtask

  task automatic bad_k(string nm, logic [KS-1:0] k);
    exp_t e;
    clr();
    @(negedge clk);
    hif.k_eph = k;
    e.v = 1'b0; e.fc = '0;
    sb.push_back(e);
    hif.go = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_done_c1"}, FW'(hif.done), '0);
    @(posedge clk); #1;
    chk({nm, "_done_c2"}, FW'(hif.done), FW'(1));
    chk({nm, "_valid_c2"}, FW'(hif.valid), '0);
    finish_run();
    chk({nm, "_gos"}, FW'(ecc_r + kdf_r + enc_r + hash_r), '0);
  endtask

  initial begin
    int t;
    hif.go = 0; hif.k_eph = '0; hif.n = KS'(19);
    hif.prime = 64'h17; hif.A = 64'h1; hif.B = 64'h3;
    hif.Gx = 64'h3; hif.Gy = 64'h4;
    hif.pubQx = 64'h7; hif.pubQy = 64'h8;
    hif.plaintext = '0; exp_pt = '0;
    #1;
    chk("rst_done", FW'(hif.done), '0);
    chk("rst_valid", FW'(hif.valid), '0);
    chk("rst_fc", hif.full_cipher, '0);
    chk("rst_gos", FW'({ecc_go, kdf_go, enc_go, hash_go}), '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    clr();
    run("nominal", KS'(5), 32'h1234_5678, 1'b1);
    chk("nom_ecc_go", FW'(ecc_r), FW'(NMUL));
    chk("nom_eng_go", FW'({kdf_r[3:0], enc_r[3:0], hash_r[3:0]}),
        FW'(12'h111));

    clr();
    run("k_max", KS'(18), 32'hCAFE_F00D, 1'b1);
    chk("kmax_ecc_go", FW'(ecc_r), FW'(NMUL));

    bad_k("k_zero", KS'(0));
    bad_k("k_eq_n", KS'(19));

    clr();
    inf2 = 1;
    run("s_inf", KS'(7), 32'h0BAD_0BAD, 1'b0);
    inf2 = 0;
    chk("sinf_kdf_go", FW'(kdf_r), '0);
    chk("sinf_ecc_go", FW'(ecc_r), FW'(NMUL));

    // Multiplier holds done high after its first job.
    clr();
    stuck = 1;
    begin
      exp_t e;
      @(negedge clk);
      hif.k_eph = KS'(9); hif.plaintext = 32'h0102_0304;
      exp_pt = 32'h0102_0304;
      e.v = 1'b1; e.fc = NOM;
      sb.push_back(e);
      hif.go = 1'b1;
    end
    t = 0;
    while (!ecc_done && t < 100) begin @(negedge clk); t++; end
    chk("stuck_seen", FW'(ecc_done), FW'(1));
    repeat (4) @(negedge clk);
    chk("stuck_go_low", FW'(ecc_go), '0);
    chk("stuck_go_cnt", FW'(ecc_r), FW'(1));
    stuck = 0;
    @(posedge clk); #1;
    chk("rearm_drop", FW'({ecc_done, ecc_go}), '0);
    @(posedge clk); #1;
    chk("rearm_rise", FW'(ecc_go), FW'(1));
    wait_done("stuck");
    finish_run();

    // Asynchronous reset while the cipher is busy.
    clr();
    @(negedge clk);
    hif.k_eph = KS'(5); hif.plaintext = 32'h1234_5678;
    exp_pt = 32'h1234_5678;
    hif.go = 1'b1;
    t = 0;
    while (!enc_go && t < 200) begin @(negedge clk); t++; end
    chk("mid_enc_seen", FW'(enc_go), FW'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst_enc_go", FW'(enc_go), '0);
    chk("arst_dv", FW'({hif.done, hif.valid}), '0);
    chk("arst_fc", hif.full_cipher, '0);
    hif.go = 1'b0;
    @(negedge clk); rst = 1'b1;
    clr();
    run("restart", KS'(5), 32'h1234_5678, 1'b1);
    chk("restart_ecc_go", FW'(ecc_r), FW'(NMUL));

`ifdef ECIES_PUBKEY_CHECK_EN
    clr();
    ord_inf = 0;
    run("q_order", KS'(5), 32'h1234_5678, 1'b0);
    ord_inf = 1;
    chk("qord_ecc_go", FW'(ecc_r), FW'(2));
    chk("qord_kdf_go", FW'(kdf_r), '0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", FW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ecies_encrypt.md
Name: ecies_encrypt

Overview:
- Sender-side ECIES controller; produces the full_cipher word (Rx || Ry || C || tag) consumed by the decrypt block.
- Sequences externally provided engines:
  - EC scalar multiplier (R = k·G, S = k·Q)
  - ANSI X9.63 KDF (on Sx)
  - symmetric encrypt engine
  - hash/MAC engine
- Sits between the RNG/host and those shared engines in the Security-Engine ECC subsystem.

Parameters:
- message_width, 32, plaintext/ciphertext width
- integer_size, 64, field element / coordinate width
- key_size, 128, scalar width (k, n)
- hashed_width, 512, tag width
- enc_key_len, 128, symmetric key bits taken from KDF output
- mac_key_length, 256, MAC key bits taken from KDF output

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- go  in  1  start request (level)
- k_eph  in  key_size  ephemeral scalar from RNG
- n  in  key_size  curve order
- prime, A, B, Gx, Gy  in  integer_size each  curve parameters
- pubQx, pubQy  in  integer_size each  recipient public key
- plaintext  in  message_width  message
- ecc_go  out  1  multiplier start
- ecc_k  out  key_size  multiplier scalar
- ecc_Px, ecc_Py  out  integer_size each  multiplier base point
- ecc_prime, ecc_A, ecc_B  out  integer_size each  multiplier curve params
- ecc_done  in  1  multiplier finished
- ecc_inf  in  1  multiplier result is point at infinity
- ecc_Rx, ecc_Ry  in  integer_size each  multiplier result
- kdf_go  out  1  KDF start
- kdf_z  out  integer_size  shared secret Sx
- kdf_done  in  1  KDF finished
- kdf_key  in  enc_key_len+mac_key_length  KDF output
- enc_go  out  1  cipher start
- enc_key  out  enc_key_len  symmetric key
- enc_data  out  message_width  plaintext to cipher
- enc_done  in  1  cipher finished
- enc_result  in  message_width  ciphertext C
- hash_go  out  1  MAC start
- mac_key  out  mac_key_length  MAC key
- hash_data  out  message_width  ciphertext to MAC
- hash_done  in  1  MAC finished
- hash_out  in  hashed_width  tag
- full_cipher  out  2*integer_size+message_width+hashed_width  packed result
- done  out  1  operation finished
- valid  out  1  full_cipher valid

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - All outputs 0, including full_cipher, all *_go, done and valid.
  - Internal registers cleared.
  - Applies mid-operation at any state; engines see their go drop immediately.
- IDLE:
  - On go=1, latch every input into registers; all later outputs derive from the registers only.
  - If k_eph==0 or k_eph>=n, go to DONEOUT with fail. No engine is started.
  - Otherwise go to GEN_R. The first ecc_go rises on the cycle after go is sampled.
- Engine handshake (all four engines):
  - The go output is held high until the matching done is sampled high on the same cycle go is high.
  - go falls on the next edge; the result is registered on that same edge.
  - A done seen while the matching go is low is ignored.
- GEN_R:
  - ecc_k=k, ecc_P=G.
  - On completion: ecc_inf=1 means fail → DONEOUT. Otherwise register Rx, Ry and go to GEN_S.
- GEN_S:
  - Wait until ecc_done=0 before raising ecc_go (engine re-arm); ecc_k=k, ecc_P=Q.
  - On completion: ecc_inf=1 means fail. Otherwise register Sx and go to KDF.
- KDF:
  - kdf_z=Sx.
  - On completion: enc_key = kdf_key[top enc_key_len bits]; mac_key = kdf_key[mac_key_length-1:0]. Go to ENCRYPT.
- ENCRYPT:
  - enc_data = plaintext register.
  - On completion: register C and go to MAC.
- MAC:
  - hash_data = C.
  - On completion: register tag, set success and go to DONEOUT.
- full_cipher packing: [MSB -: integer_size]=Rx, next integer_size=Ry, next message_width=C, [hashed_width-1:0]=tag. Defaults give Rx[671:608], Ry[607:544], C[543:512], tag[511:0].
- DONEOUT:
  - done=1; valid=success.
  - On fail, full_cipher=0.
  - Both outputs are held until go=0, then return to IDLE. Changes to go during other states are ignored.
- Total latency = 2 + sum of the engine latencies, plus 1 cycle per handshake.

Optional Feature:
- ECIES_PUBKEY_CHECK_EN, defined:
  - Adds states QINF and QORDER before GEN_R.
  - QINF: computes 1·Q; ecc_inf=1 means fail.
  - QORDER: computes n·Q; ecc_inf=0 means fail.
  - Each state uses the same handshake and re-arm rule.
- Undefined: Q is trusted; IDLE goes straight to GEN_R and the states are not synthesized.

Test Plan:
- Nominal flow with stub engines (R=(0x0A,0x0B), S=(0x0C,0x0D), kdf_key MSBs=0x11..11, enc_result=0xDEADBEEF, hash_out=512'h55…55):
  - Required: kdf_z=0x0C, enc_data=plaintext, hash_data=0xDEADBEEF.
  - Required: done=valid=1, full_cipher={64'h0A,64'h0B,32'hDEADBEEF,512'h55…55}.
- k_eph=0, then k_eph=n=19:
  - Required: no *_go ever rises; done=1, valid=0 two cycles after go.
- Stub returns ecc_inf=1 on the second multiply:
  - Required: no kdf_go; done=1, valid=0, full_cipher=0.
- ecc_done stuck high after the first multiply:
  - Required: ecc_go stays low in GEN_S until ecc_done drops, then rises the next cycle.
- Assert rst low mid-ENCRYPT:
  - Required: enc_go, done, valid and full_cipher go 0 immediately with no clock; after release plus go, the flow restarts from GEN_R.
- With ECIES_PUBKEY_CHECK_EN defined, stub returns ecc_inf=0 for n·Q:
  - Required: fail, with exactly 2 ecc_go pulses (QINF, QORDER).
